// File: rtl/mode_display_arbiter.sv
// Mode scheduler for the shared 7-segment bus and LEDs: debounced next/prev
// buttons select one mode block, with a timed banner inserted on every change.
module mode_display_arbiter #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 2_000_000,
    parameter int BLANK_CYCLES    = 50_000_000,
    parameter int CNT_W           = 28
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      btn_next,
    input  logic                      btn_prev,
    input  logic [20*NUM_MODES-1:0]   mode_seg,
    input  logic [16*NUM_MODES-1:0]   mode_led,
    output logic [NUM_MODES-1:0]      active,
    output logic [1:0]                mode_idx,
    output logic [19:0]               seg_data,
    output logic [15:0]               led,
    output logic                      mode_changed
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_BANNER = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [1:0]       LAST_IDX   = 2'(NUM_MODES - 1);

    // Index 0 is the next button, index 1 the prev button.
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [1:0]       deb_r;
    logic [1:0]       deb_d_r;
    logic [CNT_W-1:0] deb_cnt_r [2];

    logic [1:0]       press_s;
    logic             next_press_s;
    logic             prev_press_s;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] blank_cnt_r;
    logic [CNT_W-1:0] blank_cnt_s;
    logic [1:0]       mode_idx_r;
    logic [1:0]       mode_idx_s;

    logic [NUM_MODES-1:0] active_s;
    logic [19:0]          seg_s;
    logic [15:0]          led_s;
    logic                 changed_s;
    logic [19:0]          sel_seg_s;
    logic [15:0]          sel_led_s;

    function automatic logic [NUM_MODES-1:0] one_hot(input logic [1:0] idx);
        logic [NUM_MODES-1:0] r;
        for (int k = 0; k < NUM_MODES; k++) begin
            r[k] = (idx == 2'(k));
        end
        return r;
    endfunction

    // Two-stage synchronizer for both raw buttons.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {btn_prev, btn_next};
            sync2_r <= sync1_r;
        end
    end

    // Debounce: accept the synchronized level only after it has differed long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r   <= 2'b00;
            deb_d_r <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                deb_cnt_r[i] <= '0;
            end
        end else begin
            deb_d_r <= deb_r;
            for (int i = 0; i < 2; i++) begin
                if (sync2_r[i] != deb_r[i]) begin
                    if (deb_cnt_r[i] == DEB_LAST) begin
                        deb_r[i]     <= sync2_r[i];
                        deb_cnt_r[i] <= '0;
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + CNT_W'(1);
                    end
                end else begin
                    deb_cnt_r[i] <= '0;
                end
            end
        end
    end

    // Rising edges only; a same-cycle next+prev pair cancels out.
    assign press_s      = deb_r & ~deb_d_r;
    assign next_press_s = press_s[0] & ~press_s[1];
    assign prev_press_s = press_s[1] & ~press_s[0];

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RUN;
            blank_cnt_r <= '0;
            mode_idx_r  <= 2'd0;
        end else begin
            state_r     <= state_s;
            blank_cnt_r <= blank_cnt_s;
            mode_idx_r  <= mode_idx_s;
        end
    end

    // FSM next-state: a press in any state restarts the banner.
    always_comb begin
        state_s     = state_r;
        blank_cnt_s = blank_cnt_r;
        mode_idx_s  = mode_idx_r;
        if (next_press_s) begin
            mode_idx_s  = (mode_idx_r == LAST_IDX) ? 2'd0 : mode_idx_r + 2'd1;
            state_s     = ST_BANNER;
            blank_cnt_s = '0;
        end else if (prev_press_s) begin
            mode_idx_s  = (mode_idx_r == 2'd0) ? LAST_IDX : mode_idx_r - 2'd1;
            state_s     = ST_BANNER;
            blank_cnt_s = '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    blank_cnt_s = '0;
                end
                ST_BANNER: begin
                    if (blank_cnt_r == BLANK_LAST) begin
                        state_s     = ST_RUN;
                        blank_cnt_s = '0;
                    end else begin
                        blank_cnt_s = blank_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_s     = ST_RUN;
                    blank_cnt_s = '0;
                end
            endcase
        end
    end

    // FSM outputs: next values for the registered display and enable outputs.
    always_comb begin
        sel_seg_s = 20'h00000;
        sel_led_s = 16'h0000;
        for (int k = 0; k < NUM_MODES; k++) begin
            sel_seg_s = sel_seg_s | (mode_seg[20*k +: 20] & {20{mode_idx_r == 2'(k)}});
            sel_led_s = sel_led_s | (mode_led[16*k +: 16] & {16{mode_idx_r == 2'(k)}});
        end
        active_s  = (state_s == ST_RUN) ? one_hot(mode_idx_s) : '0;
        changed_s = next_press_s | prev_press_s;
        case (state_r)
            ST_RUN: begin
                seg_s = sel_seg_s;
                led_s = sel_led_s;
            end
            ST_BANNER: begin
                seg_s = {5'h1F, 5'h1F, 5'h1E, 3'b000, mode_idx_r};
                led_s = 16'h0001 << mode_idx_r;
            end
            default: begin
                seg_s = 20'h00000;
                led_s = 16'h0000;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active       <= one_hot(2'd0);
            seg_data     <= 20'h00000;
            led          <= 16'h0000;
            mode_changed <= 1'b0;
        end else begin
            active       <= active_s;
            seg_data     <= seg_s;
            led          <= led_s;
            mode_changed <= changed_s;
        end
    end

    assign mode_idx = mode_idx_r;

endmodule

// File: tb/tb_mode_display_arbiter.sv
// Scoreboard bench for mode_display_arbiter with short debounce/banner times.
module tb_mode_display_arbiter;

    localparam int NM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          btn_next;
    logic          btn_prev;
    logic [79:0]   mode_seg;
    logic [63:0]   mode_led;
    logic [3:0]    active;
    logic [1:0]    mode_idx;
    logic [19:0]   seg_data;
    logic [15:0]   led;
    logic          mode_changed;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    int       cyc = 0;
    int       chg_count = 0;
    int       chg_cyc_last = 0;
    int       chg_cyc_prev = 0;
    logic [3:0] prev_active = 4'b0001;
    bit       was_reset = 1'b1;

    mode_display_arbiter #(
        .NUM_MODES(NM), .DEBOUNCE_CYCLES(4), .BLANK_CYCLES(8), .CNT_W(28)
    ) dut (
        .clk(clk), .reset(reset), .btn_next(btn_next), .btn_prev(btn_prev),
        .mode_seg(mode_seg), .mode_led(mode_led), .active(active),
        .mode_idx(mode_idx), .seg_data(seg_data), .led(led),
        .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] exp_seg(input int k);
        logic [19:0] v;
        v = 20'(k) | (20'(k) << 15);
        return v;
    endfunction

    function automatic logic [15:0] exp_led(input int k);
        return 16'h1111 * 16'(k + 1);
    endfunction

    function automatic logic [19:0] exp_banner(input int k);
        return 20'hFFFC0 | 20'(k);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int k = 0; k < NM; k++) begin
            mode_seg[20*k +: 20] = exp_seg(k);
            mode_led[16*k +: 16] = exp_led(k);
        end
    end

    // Monitor: pops the scoreboard on every mode_changed and checks display invariants.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            was_reset   = 1'b1;
            prev_active = active;
        end else begin
            if (!was_reset) begin
                check("active_onehot0", 32'($onehot0(active)), 32'd1);
                if (mode_changed) begin
                    chg_count++;
                    chg_cyc_prev = chg_cyc_last;
                    chg_cyc_last = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_change: got mode_idx %0d expected no change", mode_idx);
                    end else begin
                        check("changed_mode_idx", 32'(mode_idx), 32'(exp_q.pop_front()));
                    end
                end
                if (active != 4'b0000 && prev_active == 4'b0000)
                    check("banner_len", 32'(cyc - chg_cyc_last), 32'd8);
                if (active != 4'b0000 && prev_active != 4'b0000) begin
                    check("active_stable", 32'(active), 32'(prev_active));
                    check("active_sel", 32'(active), 32'(4'b0001 << mode_idx));
                    check("run_seg", 32'(seg_data), 32'(exp_seg(int'(mode_idx))));
                    check("run_led", 32'(led), 32'(exp_led(int'(mode_idx))));
                end
                if (active == 4'b0000 && prev_active == 4'b0000 && !mode_changed) begin
                    check("banner_seg", 32'(seg_data), 32'(exp_banner(int'(mode_idx))));
                    check("banner_led", 32'(led), 32'(16'h0001 << mode_idx));
                end
            end
            was_reset   = 1'b0;
            prev_active = active;
        end
    end

    task automatic press(input logic n, input logic p, input int hold, input int gap);
        @(negedge clk);
        btn_next = n;
        btn_prev = p;
        repeat (hold) @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int c0;
        int t;
        logic [3:0] a0;
        reset    = 1'b1;
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_active", 32'(active), 32'h1);
        check("rst_mode_idx", 32'(mode_idx), 32'h0);
        check("rst_seg", 32'(seg_data), 32'h0);
        check("rst_led", 32'(led), 32'h0);
        check("rst_changed", 32'(mode_changed), 32'h0);
        @(negedge clk);
        check("idle_seg", 32'(seg_data), 32'h00000);
        check("idle_led", 32'(led), 32'h1111);

        // Single next press
        c0 = chg_count;
        exp_q.push_back(1);
        press(1'b1, 1'b0, 10, 12);
        check("next_pulses", 32'(chg_count - c0), 32'd1);
        check("next_idx", 32'(mode_idx), 32'd1);
        check("next_active", 32'(active), 32'b0010);
        check("next_led", 32'(led), 32'h2222);

        // Wrap backwards then forwards
        exp_q.push_back(0);
        press(1'b0, 1'b1, 10, 12);
        exp_q.push_back(3);
        press(1'b0, 1'b1, 10, 12);
        check("wrap_prev_idx", 32'(mode_idx), 32'd3);
        c0 = chg_count;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back((i + 4) % NM);
            press(1'b1, 1'b0, 10, 12);
        end
        check("wrap_next_pulses", 32'(chg_count - c0), 32'd4);
        check("wrap_next_idx", 32'(mode_idx), 32'd3);

        // Glitch shorter than the debounce time
        c0 = chg_count;
        a0 = active;
        press(1'b1, 1'b0, 3, 12);
        check("glitch_pulses", 32'(chg_count - c0), 32'd0);
        check("glitch_idx", 32'(mode_idx), 32'd3);
        check("glitch_active", 32'(active), 32'(a0));

        // Simultaneous presses cancel
        c0 = chg_count;
        press(1'b1, 1'b1, 10, 12);
        check("simul_pulses", 32'(chg_count - c0), 32'd0);
        check("simul_idx", 32'(mode_idx), 32'd3);

        // Second press lands four cycles into the banner and extends it
        c0 = chg_count;
        exp_q.push_back(2);
        exp_q.push_back(3);
        @(negedge clk);
        btn_prev = 1'b1;
        repeat (4) @(negedge clk);
        btn_next = 1'b1;
        repeat (6) @(negedge clk);
        btn_prev = 1'b0;
        repeat (4) @(negedge clk);
        btn_next = 1'b0;
        repeat (20) @(negedge clk);
        check("ext_pulses", 32'(chg_count - c0), 32'd2);
        check("ext_gap", 32'(chg_cyc_last - chg_cyc_prev), 32'd4);
        check("ext_idx", 32'(mode_idx), 32'd3);
        check("ext_active", 32'(active), 32'b1000);

        // Reset in the middle of a banner
        c0 = chg_count;
        exp_q.push_back(2);
        @(negedge clk);
        btn_prev = 1'b1;
        t = 0;
        while (chg_count == c0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("midrst_press_seen", 32'(chg_count - c0), 32'd1);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_active", 32'(active), 32'b0001);
        check("midrst_idx", 32'(mode_idx), 32'd0);
        check("midrst_seg", 32'(seg_data), 32'h0);
        check("midrst_led", 32'(led), 32'h0);
        check("midrst_changed", 32'(mode_changed), 32'h0);
        btn_prev = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idx", 32'(mode_idx), 32'd0);
        check("post_rst_active", 32'(active), 32'b0001);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
